// File: rtl/px_adc_pkg.sv
// Shared definitions for the pixel ADC emulator and the imaging ADC reader:
// pattern-mode encodings, FSM states and default serial-frame geometry.
`default_nettype none

package px_adc_pkg;

   localparam int ADC_DATA_W     = 12;
   localparam int ADC_LEAD_ZEROS = 4;
   localparam int ADC_FRAME_BITS = 16;

   typedef enum logic [1:0] {
      PAT_CONST  = 2'd0,
      PAT_RAMP   = 2'd1,
      PAT_STRIPE = 2'd2,
      PAT_CHECK  = 2'd3
   } pat_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } adc_state_e;

endpackage

`default_nettype wire

// File: rtl/px_adc_emu_if.sv
// ADC serial link: camera (master) drives cs/sclk, ADC (slave) returns data.
`default_nettype none

interface px_adc_emu_if;
   logic adc_cs;
   logic adc_sclk;
   logic adc_dout;

   modport master (output adc_cs, output adc_sclk, input adc_dout);
   modport slave  (input adc_cs, input adc_sclk, output adc_dout);
endinterface

`default_nettype wire

// File: rtl/px_adc_pattern_gen.sv
// Test-pattern source for the ADC emulator: ramp/pixel/row counters and sample mux.
// Optional LFSR dither on sample[1:0] when PX_ADC_EMU_NOISE_EN is defined.
`default_nettype none

module px_adc_pattern_gen
   import px_adc_pkg::*;
#(
   parameter int DATA_W         = ADC_DATA_W,
   parameter int PIXELS_PER_ROW = 112
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              advance_i,
   input  logic [1:0]        pattern_mode_i,
   input  logic [DATA_W-1:0] const_value_i,
   output logic [DATA_W-1:0] sample_o
);

   localparam int PIX_W = (PIXELS_PER_ROW > 1) ? $clog2(PIXELS_PER_ROW) : 1;
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS_PER_ROW - 1);

   logic [DATA_W-1:0] ramp_q;
   logic [PIX_W-1:0]  pix_q;
   logic [7:0]        row_q;
   logic [DATA_W-1:0] base_sample;
   pat_mode_e         mode;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ramp_q <= '0;
         pix_q  <= '0;
         row_q  <= '0;
      end else if (advance_i) begin
         ramp_q <= ramp_q + 1'b1;
         if (pix_q == PIX_LAST) begin
            pix_q <= '0;
            row_q <= row_q + 1'b1;
         end else begin
            pix_q <= pix_q + 1'b1;
         end
      end
   end

   assign mode = pat_mode_e'(pattern_mode_i);

   always_comb begin
      base_sample = const_value_i;
      case (mode)
         PAT_CONST:  base_sample = const_value_i;
         PAT_RAMP:   base_sample = ramp_q;
         PAT_STRIPE: base_sample = row_q[0] ? '0 : const_value_i;
         PAT_CHECK:  base_sample = (row_q[0] ^ pix_q[0]) ? '0 : const_value_i;
         default:    base_sample = const_value_i;
      endcase
   end

`ifdef PX_ADC_EMU_NOISE_EN
   logic [15:0] lfsr_q;

   // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= 16'hACE1;
      end else if (advance_i) begin
         lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end

   assign sample_o = base_sample ^ {{(DATA_W-2){1'b0}}, lfsr_q[1:0]};
`else
   assign sample_o = base_sample;
`endif

endmodule

`default_nettype wire

// File: rtl/px_adc_emu.sv
// Serial pixel ADC emulator: responds to camera cs/sclk with a zero-led, MSB-first
// pattern sample per frame. Define PX_ADC_EMU_NOISE_EN to add LFSR dither.
`default_nettype none

module px_adc_emu
   import px_adc_pkg::*;
#(
   parameter int DATA_W         = ADC_DATA_W,
   parameter int LEAD_ZEROS     = ADC_LEAD_ZEROS,
   parameter int FRAME_BITS     = ADC_FRAME_BITS,
   parameter int PIXELS_PER_ROW = 112
) (
   input  logic              clk,
   input  logic              reset,
   px_adc_emu_if.slave       adc,
   input  logic [1:0]        pattern_mode,
   input  logic [DATA_W-1:0] const_value,
   output logic              busy,
   output logic [15:0]       frame_count,
   output logic [7:0]        abort_count
);

   localparam int CNT_W = $clog2(FRAME_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

   logic cs_s1_q, cs_s2_q, cs_h_q;
   logic sclk_s1_q, sclk_s2_q, sclk_h_q;
   logic cs_fall, cs_rise, sclk_fall;

   adc_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic [DATA_W-1:0] sample_q, sample_d, pat_sample;
   logic              dout_q, dout_d;
   logic              busy_q, busy_d;
   logic [15:0]       fc_q, fc_d;
   logic [7:0]        ac_q, ac_d;
   logic              advance;

   function automatic logic frame_bit(input logic [DATA_W-1:0] s, input logic [CNT_W-1:0] k);
      int ki;
      logic [DATA_W-1:0] t;
      ki = int'(k);
      t  = '0;
      if (ki >= LEAD_ZEROS && ki < LEAD_ZEROS + DATA_W) begin
         t = s << (ki - LEAD_ZEROS);
      end
      return t[DATA_W-1];
   endfunction

   // Synchronisers idle high so reset never looks like a cs/sclk falling edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         cs_h_q    <= 1'b1;
         sclk_s1_q <= 1'b1;
         sclk_s2_q <= 1'b1;
         sclk_h_q  <= 1'b1;
      end else begin
         cs_s1_q   <= adc.adc_cs;
         cs_s2_q   <= cs_s1_q;
         cs_h_q    <= cs_s2_q;
         sclk_s1_q <= adc.adc_sclk;
         sclk_s2_q <= sclk_s1_q;
         sclk_h_q  <= sclk_s2_q;
      end
   end

   assign cs_fall   = cs_h_q & ~cs_s2_q;
   assign cs_rise   = ~cs_h_q & cs_s2_q;
   assign sclk_fall = sclk_h_q & ~sclk_s2_q;
   assign cnt_inc   = cnt_q + 1'b1;

   px_adc_pattern_gen #(
      .DATA_W         (DATA_W),
      .PIXELS_PER_ROW (PIXELS_PER_ROW)
   ) u_pattern (
      .clk            (clk),
      .reset          (reset),
      .advance_i      (advance),
      .pattern_mode_i (pattern_mode),
      .const_value_i  (const_value),
      .sample_o       (pat_sample)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sample_q <= '0;
         dout_q   <= 1'b0;
         busy_q   <= 1'b0;
         fc_q     <= '0;
         ac_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
         dout_q   <= dout_d;
         busy_q   <= busy_d;
         fc_q     <= fc_d;
         ac_q     <= ac_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sample_d = sample_q;
      dout_d   = dout_q;
      busy_d   = busy_q;
      fc_d     = fc_q;
      ac_d     = ac_q;
      advance  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dout_d = 1'b0;
            busy_d = 1'b0;
            if (cs_fall) begin
               sample_d = pat_sample;
               cnt_d    = '0;
               busy_d   = 1'b1;
               dout_d   = frame_bit(pat_sample, '0);
               state_d  = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            // A final sclk edge coinciding with cs rise still completes the frame
            if (sclk_fall && cnt_q == LAST_IDX) begin
               cnt_d   = cnt_inc;
               dout_d  = 1'b0;
               fc_d    = fc_q + 1'b1;
               advance = 1'b1;
               if (cs_rise) begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
            end else if (cs_rise) begin
               busy_d  = 1'b0;
               dout_d  = 1'b0;
               state_d = ST_IDLE;
               if (ac_q != 8'hFF) begin
                  ac_d = ac_q + 1'b1;
               end
            end else if (sclk_fall) begin
               cnt_d  = cnt_inc;
               dout_d = frame_bit(sample_q, cnt_inc);
            end
         end
         ST_HOLD: begin
            dout_d = 1'b0;
            if (cs_rise) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            dout_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign adc.adc_dout = dout_q;
   assign busy         = busy_q;
   assign frame_count  = fc_q;
   assign abort_count  = ac_q;

endmodule

`default_nettype wire

// File: tb/tb_px_adc_emu.sv
// Directed self-checking bench for px_adc_emu (PIXELS_PER_ROW=4, sclk = clk/8).
`default_nettype none

module tb_px_adc_emu;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  pattern_mode;
   logic [11:0] const_value;
   logic        busy;
   logic [15:0] frame_count;
   logic [7:0]  abort_count;

   int errors = 0;
   int checks = 0;

   px_adc_emu_if ifc ();

   px_adc_emu #(
      .DATA_W         (12),
      .LEAD_ZEROS     (4),
      .FRAME_BITS     (16),
      .PIXELS_PER_ROW (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .adc          (ifc),
      .pattern_mode (pattern_mode),
      .const_value  (const_value),
      .busy         (busy),
      .frame_count  (frame_count),
      .abort_count  (abort_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sclk_pulse(output logic b);
      b = ifc.adc_dout;
      ifc.adc_sclk = 1'b0;
      clk_n(4);
      ifc.adc_sclk = 1'b1;
      clk_n(4);
   endtask

   // One full 16-bit frame; optionally rewrites const_value after bit chg_at
   task automatic read_frame(output logic [15:0] w, output logic busy_in, output logic busy_after,
                             input int chg_at, input logic [11:0] new_const);
      logic b;
      ifc.adc_cs = 1'b0;
      clk_n(8);
      busy_in = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (busy !== 1'b1) busy_in = 1'b0;
         sclk_pulse(b);
         w[15-k] = b;
         if (k == chg_at) const_value = new_const;
      end
      if (busy !== 1'b1) busy_in = 1'b0;
      ifc.adc_cs = 1'b1;
      clk_n(8);
      busy_after = busy;
   endtask

   task automatic abort_after(input int nfall, output logic busy_pre, output logic dout_pre,
                              output logic busy_post, output logic dout_post);
      logic b;
      ifc.adc_cs = 1'b0;
      clk_n(8);
      for (int k = 0; k < nfall; k++) sclk_pulse(b);
      ifc.adc_cs = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      busy_pre = busy;
      dout_pre = ifc.adc_dout;
      @(posedge clk);
      #1;
      busy_post = busy;
      dout_post = ifc.adc_dout;
      clk_n(8);
   endtask

   initial begin
      logic [15:0] w;
      logic        bi, ba, bp, dp, bq, dq, b;
      int          bad;

      reset        = 1'b1;
      ifc.adc_cs   = 1'b1;
      ifc.adc_sclk = 1'b1;
      pattern_mode = 2'd1;
      const_value  = 12'h000;
      clk_n(3);
      check("reset_busy", busy, 0);
      check("reset_dout", ifc.adc_dout, 0);
      check("reset_fc", frame_count, 0);
      check("reset_ac", abort_count, 0);
      reset = 1'b0;
      clk_n(4);

      // Ramp: three frames 0,1,2
      read_frame(w, bi, ba, -1, 12'h000);
      check("ramp0_word", w, 16'h0000);
      read_frame(w, bi, ba, -1, 12'h000);
      check("ramp1_word", w, 16'h0001);
      check("ramp1_lead", w[15:12], 4'h0);
      read_frame(w, bi, ba, -1, 12'h000);
      check("ramp2_word", w, 16'h0002);
      check("ramp_fc", frame_count, 3);

      // Constant, with const_value rewritten mid-frame
      pattern_mode = 2'd0;
      const_value  = 12'hA5C;
      read_frame(w, bi, ba, 6, 12'h123);
      check("const_word", w, 16'h0A5C);
      check("const_busy_in", bi, 1);
      check("const_busy_after", ba, 0);
      check("const_fc", frame_count, 4);

      // Ramp abort after 7 falls (ramp counter now 4)
      pattern_mode = 2'd1;
      abort_after(7, bp, dp, bq, dq);
      check("abort_busy_pre", bp, 1);
      check("abort_busy_post", bq, 0);
      check("abort_dout_post", dq, 0);
      check("abort_ac", abort_count, 1);
      check("abort_fc", frame_count, 4);

      // Constant 0xFFF abort: frame bit 7 is a 1 right up to the abort
      pattern_mode = 2'd0;
      const_value  = 12'hFFF;
      abort_after(7, bp, dp, bq, dq);
      check("abort2_dout_pre", dp, 1);
      check("abort2_dout_post", dq, 0);
      check("abort2_busy_post", bq, 0);
      check("abort2_ac", abort_count, 2);

      pattern_mode = 2'd1;
      read_frame(w, bi, ba, -1, 12'h000);
      check("ramp_repeat_word", w, 16'h0004);
      check("ramp_repeat_fc", frame_count, 5);

      // sclk while cs is high is ignored
      for (int k = 0; k < 3; k++) sclk_pulse(b);
      check("cs_high_busy", busy, 0);
      check("cs_high_fc", frame_count, 5);

      // 20 extra sclk pulses after the 16th with cs held low
      ifc.adc_cs = 1'b0;
      clk_n(8);
      for (int k = 0; k < 16; k++) begin
         sclk_pulse(b);
         w[15-k] = b;
      end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (ifc.adc_dout !== 1'b0) bad++;
         ifc.adc_sclk = 1'b0;
         clk_n(4);
         if (ifc.adc_dout !== 1'b0) bad++;
         ifc.adc_sclk = 1'b1;
         clk_n(4);
      end
      check("extra_word", w, 16'h0005);
      check("extra_dout_nonzero", bad, 0);
      check("extra_busy", busy, 1);
      ifc.adc_cs = 1'b1;
      clk_n(8);
      check("extra_fc", frame_count, 6);

      // Reset mid-frame at bit 9
      ifc.adc_cs = 1'b0;
      clk_n(8);
      for (int k = 0; k < 9; k++) sclk_pulse(b);
      reset = 1'b1;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_fc", frame_count, 0);
      check("midrst_ac", abort_count, 0);
      check("midrst_dout", ifc.adc_dout, 0);
      ifc.adc_cs = 1'b1;
      clk_n(4);
      reset = 1'b0;
      clk_n(4);
      check("midrst_idle_busy", busy, 0);
      read_frame(w, bi, ba, -1, 12'h000);
      check("midrst_ramp_word", w, 16'h0000);

      // Stripes from a clean row 0 / pix 0
      reset = 1'b1;
      clk_n(2);
      reset = 1'b0;
      clk_n(4);
      pattern_mode = 2'd2;
      const_value  = 12'hFFF;
      for (int f = 0; f < 8; f++) begin
         read_frame(w, bi, ba, -1, 12'hFFF);
         check($sformatf("stripe%0d", f), w, (f < 4) ? 16'h0FFF : 16'h0000);
      end

      // Checker on row 2
      pattern_mode = 2'd3;
      const_value  = 12'h3C3;
      for (int f = 0; f < 4; f++) begin
         read_frame(w, bi, ba, -1, 12'h3C3);
         check($sformatf("checker%0d", f), w, (f % 2 == 0) ? 16'h03C3 : 16'h0000);
      end
      check("checker_fc", frame_count, 12);

      // abort_count saturation
      for (int k = 0; k < 260; k++) begin
         ifc.adc_cs = 1'b0;
         clk_n(6);
         ifc.adc_cs = 1'b1;
         clk_n(6);
      end
      check("abort_sat", abort_count, 8'hFF);
      check("abort_sat_fc", frame_count, 12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
